// File: rtl/vs_uart_pkg.sv
// Shared UART definitions: receiver state encoding, frame geometry and parity helper.
// Intended for reuse by uart_rx and a future uart_tx.
package vs_uart_pkg;

    localparam int UART_DATA_BITS    = 8;
    localparam int UART_CLKS_PER_BIT = 434;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BREAK  = 3'd5
    } rx_state_t;

    // Parity bit that makes the total count of ones (data + parity) even.
    function automatic logic even_parity(input logic [UART_DATA_BITS-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input, with a configurable reset level.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_r;

    // Metastability filter: d -> meta_r -> q.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_r <= RESET_VAL;
            q      <= RESET_VAL;
        end else begin
            meta_r <= d;
            q      <= meta_r;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 serial receiver (8O1/8E1 when UART_RX_PARITY_EN is defined); emits good bytes with a
// one-cycle rxfinish strobe and flags framing/parity errors without ever emitting a bad byte.
module uart_rx
    import vs_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int PARITY_ODD   = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rxdata,
    output logic       rxfinish,
    output logic       frame_err,
    output logic       parity_err,
    output logic       busy
);

    localparam int TW   = $clog2(CLKS_PER_BIT);
    localparam int HALF = CLKS_PER_BIT / 32'sd2;
    localparam logic [TW-1:0] T_ZERO  = TW'(32'sd0);
    localparam logic [TW-1:0] T_ONE   = TW'(32'sd1);
    localparam logic [TW-1:0] HALF_TC = TW'(HALF - 32'sd1);
    localparam logic [TW-1:0] BIT_TC  = TW'(CLKS_PER_BIT - 32'sd1);

    logic                      rx_s;
    logic                      tc_s;
    logic                      load_s;
    logic                      ferr_s;
    rx_state_t                 state_r, state_nxt_s;
    logic [TW-1:0]             timer_r, timer_nxt_s;
    logic [2:0]                bit_idx_r, bit_idx_nxt_s;
    logic [UART_DATA_BITS-1:0] shreg_r, shreg_nxt_s;

`ifdef UART_RX_PARITY_EN
    logic par_bad_r, par_bad_nxt_s;
    logic perr_s;
    logic parity_err_r;
    assign parity_err = parity_err_r;
`else
    // No parity bit on the line; the parity sense has no effect in this build.
    assign parity_err = 1'b0 & PARITY_ODD[0];
`endif

    sync_2ff #(.RESET_VAL(1'b1)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx),
        .q   (rx_s)
    );

    assign tc_s = (timer_r == BIT_TC);

    // Next-state, bit timer, shifter and completion decisions.
    always_comb begin
        state_nxt_s   = state_r;
        timer_nxt_s   = timer_r + T_ONE;
        bit_idx_nxt_s = bit_idx_r;
        shreg_nxt_s   = shreg_r;
        load_s        = 1'b0;
        ferr_s        = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_nxt_s = par_bad_r;
        perr_s        = 1'b0;
`endif
        case (state_r)
            IDLE: begin
                timer_nxt_s = T_ZERO;
                if (!rx_s) begin
                    state_nxt_s = START;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            START: begin
                // Re-check the line mid start bit to reject glitches.
                if (timer_r == HALF_TC) begin
                    timer_nxt_s = T_ZERO;
                    if (rx_s) begin
                        state_nxt_s = IDLE;
                    end else begin
                        state_nxt_s   = DATA;
                        bit_idx_nxt_s = 3'd0;
                    end
                end else begin
                    state_nxt_s = START;
                end
            end
            DATA: begin
                if (tc_s) begin
                    timer_nxt_s = T_ZERO;
                    shreg_nxt_s = {rx_s, shreg_r[UART_DATA_BITS-1:1]};
                    if (bit_idx_r == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_nxt_s = PARITY;
`else
                        state_nxt_s = STOP;
`endif
                    end else begin
                        bit_idx_nxt_s = bit_idx_r + 3'd1;
                    end
                end else begin
                    state_nxt_s = DATA;
                end
            end
            PARITY: begin
`ifdef UART_RX_PARITY_EN
                if (tc_s) begin
                    timer_nxt_s   = T_ZERO;
                    par_bad_nxt_s = (rx_s != (even_parity(shreg_r) ^ PARITY_ODD[0]));
                    state_nxt_s   = STOP;
                end else begin
                    state_nxt_s = PARITY;
                end
`else
                timer_nxt_s = T_ZERO;
                state_nxt_s = IDLE;
`endif
            end
            STOP: begin
                if (tc_s) begin
                    timer_nxt_s = T_ZERO;
`ifdef UART_RX_PARITY_EN
                    par_bad_nxt_s = 1'b0;
`endif
                    if (rx_s) begin
                        state_nxt_s = IDLE;
`ifdef UART_RX_PARITY_EN
                        if (par_bad_r) begin
                            perr_s = 1'b1;
                        end else begin
                            load_s = 1'b1;
                        end
`else
                        load_s = 1'b1;
`endif
                    end else begin
                        ferr_s      = 1'b1;
                        state_nxt_s = BREAK;
                    end
                end else begin
                    state_nxt_s = STOP;
                end
            end
            BREAK: begin
                timer_nxt_s = T_ZERO;
                if (rx_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = BREAK;
                end
            end
            default: begin
                timer_nxt_s = T_ZERO;
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State, datapath and registered strobe outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            timer_r   <= T_ZERO;
            bit_idx_r <= 3'd0;
            shreg_r   <= 8'h00;
            rxdata    <= 8'h00;
            rxfinish  <= 1'b0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            timer_r   <= timer_nxt_s;
            bit_idx_r <= bit_idx_nxt_s;
            shreg_r   <= shreg_nxt_s;
            if (load_s) begin
                rxdata <= shreg_r;
            end else begin
                rxdata <= rxdata;
            end
            rxfinish  <= load_s;
            frame_err <= ferr_s;
            busy      <= (state_nxt_s != IDLE);
        end
    end

`ifdef UART_RX_PARITY_EN
    // Latched parity verdict and its error strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            par_bad_r    <= 1'b0;
            parity_err_r <= 1'b0;
        end else begin
            par_bad_r    <= par_bad_nxt_s;
            parity_err_r <= perr_s;
        end
    end
`endif

endmodule
